// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin memory bus arbiter.
// Each granted access goes IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (one ack cycle) -> IDLE.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              notReset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr,
  output logic              rd,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] cnt;
  logic       last_served;
  logic       grant1;
  req_t       sel;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    grant1    = req1 & (~req0 | ~last_served);
    sel.we    = grant1 ? we1    : we0;
    sel.addr  = grant1 ? addr1  : addr0;
    sel.wdata = grant1 ? wdata1 : wdata0;
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_served <= 1'b1;
      wr          <= 1'b0;
      rd          <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state       <= ACCESS;
            busy        <= 1'b1;
            cnt         <= WS_INIT;
            last_served <= grant1;
            mem_addr    <= sel.addr;
            mem_wdata   <= sel.wdata;
            wr          <= sel.we;
            rd          <= ~sel.we;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            wr    <= 1'b0;
            rd    <= 1'b0;
            ack0  <= ~last_served;
            ack1  <= last_served;
            // rd mirrors the latched direction for the whole access
            if (rd) rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          wr    <= 1'b0;
          rd    <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, data width.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, extra strobe cycles per access, legal range 0..15.
REQ-004 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port notReset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports req0, req1  input  1 each  access request from requester 0 (CPU) and requester 1 (secondary master).
REQ-007 The block SHALL have ports we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 The block SHALL have ports addr0, addr1  input  ADDR_W each  access address.
REQ-009 The block SHALL have ports wdata0, wdata1  input  DATA_W each  write data.
REQ-010 The block SHALL have ports ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 The block SHALL have port rdata  output  DATA_W  read data, shared by both requesters.
REQ-012 The block SHALL have ports mem_addr  output  ADDR_W and mem_wdata  output  DATA_W  memory bus address and write data.
REQ-013 The block SHALL have port mem_rdata  input  DATA_W  memory read data.
REQ-014 The block SHALL have ports wr, rd  output  1 each  active-high strobe requests into the existing wr/rd strobe register.
REQ-015 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, ACCESS and DONE.
REQ-017 IDLE: if any req is high at an edge, the block SHALL latch the winner's we/addr/wdata and the winner index, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: when only one req is high, that requester wins; when both are high, the requester not served last wins.
REQ-019 ACCESS SHALL last exactly WAIT_STATES+1 cycles, counted by a 4-bit down-counter loaded with WAIT_STATES, then the block SHALL go to DONE.
REQ-020 During ACCESS, wr SHALL equal the latched we and rd its inverse; in all other states wr=rd=0.
REQ-021 During ACCESS, mem_addr and mem_wdata SHALL drive the latched values; all memory-side outputs SHALL be registered.
REQ-022 For a read, rdata SHALL capture mem_rdata on the edge ending the last ACCESS cycle and hold it until the next read capture; writes SHALL leave rdata unchanged.
REQ-023 DONE SHALL last one cycle, with ack of the served requester high and the other ack low, then the block SHALL return to IDLE.
REQ-024 Latency SHALL be: req sampled at edge E0, ack high during cycle E0+WAIT_STATES+1 to E0+WAIT_STATES+2.
REQ-025 A requester SHALL hold req/we/addr/wdata stable until ack and SHALL clear req on the edge that samples ack high; a req still high in IDLE after that edge SHALL be treated as a new request.
REQ-026 A req changing during ACCESS or DONE SHALL have no effect on the access in progress.
REQ-027 Back-to-back accesses SHALL be separated by at least one IDLE cycle.

Reset
REQ-028 While notReset=0, the block SHALL be in state IDLE, with wr=rd=0, ack0=ack1=0, busy=0, mem_addr=0, mem_wdata=0, rdata=0, counter=0 and last-served=1, so requester 0 wins the first tie.
REQ-029 A reset asserted mid-ACCESS SHALL drop wr/rd immediately and no ack SHALL be issued for the aborted access.

Verification
REQ-030 Read, WAIT_STATES=1: req0=1, we0=0, addr0=0x1234, mem_rdata=0xBEEF -> rd high for 2 cycles, mem_addr=0x1234, ack0 pulse 2 cycles after the sampling edge, rdata=0xBEEF.
REQ-031 Write, WAIT_STATES=0: req1=1, we1=1, addr1=0x0010, wdata1=0x00A5 -> wr high for 1 cycle, mem_wdata=0x00A5, ack1 pulse, rdata unchanged.
REQ-032 Tie after reset: req0=req1=1 held with correct handshaking -> grant order 0,1,0,1 with an IDLE cycle between accesses, and ack never high on both ports at once.
REQ-033 Mid-access reset: notReset=0 during the 3rd ACCESS cycle with WAIT_STATES=5 -> wr/rd=0 at once, no ack, and the state is IDLE after release.
REQ-034 Request stealing: req0 access in progress, req1 rises during ACCESS -> the req0 access completes unaltered, then req1 is granted from the next IDLE.
